// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue
//   Consumes key events from ps2_host_keyboard, tracks the modifier keys
//   (left/right shift, ctrl, alt) and queues each event with a modifier
//   snapshot in a FIFO. A consumer drains the FIFO with a valid/ack handshake.
//
//   Event word: [15:10] modifiers, [9] release, [8] extended, [7:0] key_number
//
// Ports:
//   clk, clk__enable, reset_n      clock, clock enable, async active-low reset
//   ps2_key__*                     incoming key event (one-cycle valid pulse)
//   key_event_ack                  pops the head entry when key_event__valid
//   overflow_clear                 clears the sticky overflow flag
//   key_event__valid/__data        FIFO head
//   modifiers                      live modifier state
//   fifo_count                     entries held
//   overflow                       sticky: an event was dropped while full
//
// Optional build macro: PS2_KEY_REPEAT_FILTER_EN
//   Suppresses typematic repeats of the most recently pressed key.

module ps2_key_event_queue #(
  parameter int fifo_log2_depth = 3
) (
  input  logic                     clk,
  input  logic                     clk__enable,
  input  logic                     reset_n,
  input  logic                     ps2_key__valid,
  input  logic                     ps2_key__extended,
  input  logic                     ps2_key__release,
  input  logic [7:0]               ps2_key__key_number,
  input  logic                     key_event_ack,
  input  logic                     overflow_clear,
  output logic                     key_event__valid,
  output logic [15:0]              key_event__data,
  output logic [5:0]               modifiers,
  output logic [fifo_log2_depth:0] fifo_count,
  output logic                     overflow
);

  localparam int DEPTH = 1 << fifo_log2_depth;
  localparam int PW    = fifo_log2_depth;
  localparam int CW    = fifo_log2_depth + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0]    mod_q, mod_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   mem_q [DEPTH];

  logic [15:0]   event_word;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;

  // Modifier decode; the event word carries the post-update state.
  always_comb begin
    mod_d = mod_q;
    if (ps2_key__valid) begin
      case ({ps2_key__extended, ps2_key__key_number})
        9'h012:  mod_d[0] = ~ps2_key__release;
        9'h059:  mod_d[1] = ~ps2_key__release;
        9'h014:  mod_d[2] = ~ps2_key__release;
        9'h114:  mod_d[3] = ~ps2_key__release;
        9'h011:  mod_d[4] = ~ps2_key__release;
        9'h111:  mod_d[5] = ~ps2_key__release;
        default: ;
      endcase
    end
    event_word = {mod_d, ps2_key__release, ps2_key__extended, ps2_key__key_number};
  end

`ifdef PS2_KEY_REPEAT_FILTER_EN
  logic [8:0] held_key_q, held_key_d;
  logic       held_valid_q, held_valid_d;
  logic       key_match;

  // A press of the currently held key is a typematic repeat and is not queued.
  always_comb begin
    key_match    = held_valid_q && (held_key_q == {ps2_key__extended, ps2_key__key_number});
    held_key_d   = held_key_q;
    held_valid_d = held_valid_q;
    push_req     = ps2_key__valid;
    if (ps2_key__valid) begin
      if (!ps2_key__release) begin
        if (key_match) begin
          push_req = 1'b0;
        end else begin
          held_key_d   = {ps2_key__extended, ps2_key__key_number};
          held_valid_d = 1'b1;
        end
      end else if (key_match) begin
        held_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_key_q   <= '0;
      held_valid_q <= 1'b0;
    end else if (clk__enable) begin
      held_key_q   <= held_key_d;
      held_valid_q <= held_valid_d;
    end
  end
`else
  assign push_req = ps2_key__valid;
`endif

  always_comb begin
    pop  = (count_q != '0) && key_event_ack;
    full = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = push_req && (!full || pop);

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear.
    overflow_d = (overflow_q && !overflow_clear) || (push_req && full && !pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mod_q      <= '0;
      overflow_q <= 1'b0;
    end else if (clk__enable) begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mod_q      <= mod_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (clk__enable && push_ok) begin
      mem_q[wr_ptr_q] <= event_word;
    end
  end

  assign key_event__valid = (count_q != '0);
  assign key_event__data  = key_event__valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign modifiers        = mod_q;
  assign fifo_count       = count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
module tb_ps2_key_event_queue;

  logic        clk = 1'b0;
  logic        clk__enable;
  logic        reset_n;
  logic        ps2_key__valid;
  logic        ps2_key__extended;
  logic        ps2_key__release;
  logic [7:0]  ps2_key__key_number;
  logic        key_event_ack;
  logic        overflow_clear;
  logic        key_event__valid;
  logic [15:0] key_event__data;
  logic [5:0]  modifiers;
  logic [3:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  ps2_key_event_queue #(.fifo_log2_depth(3)) dut (
    .clk                 (clk),
    .clk__enable         (clk__enable),
    .reset_n             (reset_n),
    .ps2_key__valid      (ps2_key__valid),
    .ps2_key__extended   (ps2_key__extended),
    .ps2_key__release    (ps2_key__release),
    .ps2_key__key_number (ps2_key__key_number),
    .key_event_ack       (key_event_ack),
    .overflow_clear      (overflow_clear),
    .key_event__valid    (key_event__valid),
    .key_event__data     (key_event__data),
    .modifiers           (modifiers),
    .fifo_count          (fifo_count),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic send_key(input logic rel, input logic ext, input logic [7:0] code);
    ps2_key__valid      = 1'b1;
    ps2_key__release    = rel;
    ps2_key__extended   = ext;
    ps2_key__key_number = code;
    @(negedge clk);
    ps2_key__valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    check({tag, "_valid"}, 16'(key_event__valid), 16'h0001);
    check(tag, key_event__data, exp);
    key_event_ack = 1'b1;
    @(negedge clk);
    key_event_ack = 1'b0;
  endtask

  initial begin
    clk__enable         = 1'b1;
    reset_n             = 1'b0;
    ps2_key__valid      = 1'b0;
    ps2_key__extended   = 1'b0;
    ps2_key__release    = 1'b0;
    ps2_key__key_number = 8'h00;
    key_event_ack       = 1'b0;
    overflow_clear      = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid", 16'(key_event__valid), 16'h0000);
    check("rst_data",  key_event__data, 16'h0000);
    check("rst_count", 16'(fifo_count), 16'h0000);
    check("rst_mods",  16'(modifiers), 16'h0000);
    check("rst_ovf",   16'(overflow), 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    // Single key A
    send_key(1'b0, 1'b0, 8'h1C);
    check("a_valid", 16'(key_event__valid), 16'h0001);
    check("a_data",  key_event__data, 16'h001C);
    check("a_count", 16'(fifo_count), 16'h0001);
    key_event_ack = 1'b1;
    @(negedge clk);
    key_event_ack = 1'b0;
    check("a_pop_valid", 16'(key_event__valid), 16'h0000);
    check("a_pop_count", 16'(fifo_count), 16'h0000);

    // Ack while empty is ignored
    key_event_ack = 1'b1;
    @(negedge clk);
    key_event_ack = 1'b0;
    check("empty_ack_count", 16'(fifo_count), 16'h0000);

    // Shift-A
    send_key(1'b0, 1'b0, 8'h12);
    check("lshift_mods", 16'(modifiers), 16'h0001);
    send_key(1'b0, 1'b0, 8'h1C);
    send_key(1'b1, 1'b0, 8'h12);
    check("shift_count", 16'(fifo_count), 16'h0003);
    check("shift_mods",  16'(modifiers), 16'h0000);
    pop_expect("shift_e0", 16'h0412);
    pop_expect("shift_e1", 16'h041C);
    pop_expect("shift_e2", 16'h0212);

    // Right ctrl, right alt (extended)
    send_key(1'b0, 1'b1, 8'h14);
    send_key(1'b0, 1'b1, 8'h11);
    check("ext_mods", 16'(modifiers), 16'h0028);
    pop_expect("ext_e0", 16'h2114);
    pop_expect("ext_e1", 16'hA111);
    send_key(1'b1, 1'b1, 8'h14);
    send_key(1'b1, 1'b1, 8'h11);
    pop_expect("ext_rel0", 16'h8314);
    pop_expect("ext_rel1", 16'h0311);
    check("ext_mods_end", 16'(modifiers), 16'h0000);

    // Back-to-back fill, 9th dropped with overflow_clear in the same cycle
    for (int i = 0; i < 8; i++) begin
      ps2_key__valid      = 1'b1;
      ps2_key__release    = 1'b0;
      ps2_key__extended   = 1'b0;
      ps2_key__key_number = 8'h20 + 8'(i);
      @(negedge clk);
    end
    ps2_key__key_number = 8'h28;
    overflow_clear      = 1'b1;
    @(negedge clk);
    ps2_key__valid = 1'b0;
    overflow_clear = 1'b0;
    check("full_count", 16'(fifo_count), 16'h0008);
    check("full_ovf",   16'(overflow), 16'h0001);
    for (int i = 0; i < 8; i++) pop_expect("drain", 16'h0020 + 16'(i));
    check("drain_count", 16'(fifo_count), 16'h0000);
    check("ovf_sticky",  16'(overflow), 16'h0001);
    overflow_clear = 1'b1;
    @(negedge clk);
    overflow_clear = 1'b0;
    check("ovf_clear", 16'(overflow), 16'h0000);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) send_key(1'b0, 1'b0, 8'h30 + 8'(i));
    ps2_key__valid      = 1'b1;
    ps2_key__key_number = 8'h40;
    key_event_ack       = 1'b1;
    @(negedge clk);
    ps2_key__valid = 1'b0;
    key_event_ack  = 1'b0;
    check("pp_count", 16'(fifo_count), 16'h0008);
    check("pp_ovf",   16'(overflow), 16'h0000);
    for (int i = 1; i < 8; i++) pop_expect("pp_drain", 16'h0030 + 16'(i));
    pop_expect("pp_last", 16'h0040);

    // Push and ack together while empty: push lands
    ps2_key__valid      = 1'b1;
    ps2_key__key_number = 8'h15;
    key_event_ack       = 1'b1;
    @(negedge clk);
    ps2_key__valid = 1'b0;
    key_event_ack  = 1'b0;
    check("epp_count", 16'(fifo_count), 16'h0001);
    pop_expect("epp_data", 16'h0015);

    // Clock enable low: inputs ignored
    clk__enable = 1'b0;
    send_key(1'b0, 1'b0, 8'h12);
    check("ce_count", 16'(fifo_count), 16'h0000);
    check("ce_mods",  16'(modifiers), 16'h0000);
    clk__enable = 1'b1;

    // Mid-stream async reset
    send_key(1'b0, 1'b0, 8'h12);
    send_key(1'b0, 1'b0, 8'h1C);
    check("pre_rst_count", 16'(fifo_count), 16'h0002);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(key_event__valid), 16'h0000);
    check("mid_rst_data",  key_event__data, 16'h0000);
    check("mid_rst_count", 16'(fifo_count), 16'h0000);
    check("mid_rst_mods",  16'(modifiers), 16'h0000);
    check("mid_rst_ovf",   16'(overflow), 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Typematic repeat
    repeat (3) send_key(1'b0, 1'b0, 8'h1C);
    send_key(1'b1, 1'b0, 8'h1C);
`ifdef PS2_KEY_REPEAT_FILTER_EN
    check("rep_count", 16'(fifo_count), 16'h0002);
    pop_expect("rep_e0", 16'h001C);
    pop_expect("rep_e1", 16'h021C);
`else
    check("rep_count", 16'(fifo_count), 16'h0004);
    pop_expect("rep_e0", 16'h001C);
    pop_expect("rep_e1", 16'h001C);
    pop_expect("rep_e2", 16'h001C);
    pop_expect("rep_e3", 16'h021C);
`endif
    check("rep_end_count", 16'(fifo_count), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
